// File: rtl/rf_arbiter_if.sv
// Host/debug port bundle for the register-file arbiter.
// The host side drives the request fields; the arbiter returns ack, read data and error.
interface rf_arbiter_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [WIDTH-1:0]  host_wdata;
  logic              host_ack;
  logic [WIDTH-1:0]  host_rdata;
  logic              host_err;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata, host_err
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata, host_err
  );
endinterface

// File: rtl/rf_arbiter.sv
// Register-file arbiter: core has zero-latency pass-through priority, the host is served
// when the core is idle or after STARVE_MAX contended cycles, stalling the core meanwhile.
//
// state   | meaning
// IDLE    | core owns the file; host request may be captured here
// HOST    | captured host access presented to the register file
// HOST_RD | waiting one cycle for register-file read data
// ACK     | host_ack pulse with error flag and read data
module rf_arbiter #(
  parameter int WIDTH      = 16,
  parameter int REG_NUM    = 16,
  parameter int ADDR_W     = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_en,
  input  logic              core_r_or_w,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [WIDTH-1:0]  core_wdata,
  output logic              core_stall,
  rf_arbiter_if.slave       host,
  output logic              rf_en,
  output logic              rf_r_or_w,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [WIDTH-1:0]  rf_wdata,
  input  logic [WIDTH-1:0]  rf_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_TOP = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, HOST, HOST_RD, ACK} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  starve_cnt;
  logic              cap_we;
  logic              cap_inv;
  logic [ADDR_W-1:0] cap_addr;
  logic [WIDTH-1:0]  cap_wdata;
  logic [WIDTH-1:0]  rdata_q;
  logic              grant;
  logic              addr_inv;

  assign addr_inv = (32'(host.host_addr) >= 32'(REG_NUM));
  assign grant    = host.host_req && (!core_en || (starve_cnt == STARVE_TOP));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = HOST;
      HOST:    state_nxt = (!cap_inv && !cap_we) ? HOST_RD : ACK;
      HOST_RD: state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Host fields are frozen at grant so the host bus is free to change afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
      cap_we     <= 1'b0;
      cap_inv    <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      rdata_q    <= '0;
    end else begin
      if (state == IDLE) begin
        if (grant) begin
          cap_we     <= host.host_we;
          cap_inv    <= addr_inv;
          cap_addr   <= host.host_addr;
          cap_wdata  <= host.host_wdata;
          starve_cnt <= '0;
          rdata_q    <= '0;
        end else if (host.host_req) begin
          if (starve_cnt != STARVE_TOP) starve_cnt <= starve_cnt + CNT_W'(1);
        end else begin
          starve_cnt <= '0;
        end
      end
      if (state == HOST_RD) rdata_q <= rf_rdata;
    end
  end

  always_comb begin
    rf_en           = 1'b0;
    rf_r_or_w       = 1'b0;
    rf_addr         = '0;
    rf_wdata        = '0;
    core_stall      = (state != IDLE);
    host.host_ack   = (state == ACK);
    host.host_err   = (state == ACK) && cap_inv;
    host.host_rdata = rdata_q;
    case (state)
      IDLE: begin
        rf_en     = core_en;
        rf_r_or_w = core_r_or_w;
        rf_addr   = core_addr;
        rf_wdata  = core_wdata;
      end
      HOST: begin
        rf_en     = !cap_inv;
        rf_r_or_w = !cap_we;
        rf_addr   = cap_addr;
        rf_wdata  = cap_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rf_arbiter.sv
// Scoreboard bench for rf_arbiter: directed host/core traffic against a register-file model,
// with host responses checked by an independent monitor.
module tb_rf_arbiter;
  localparam int WIDTH      = 16;
  localparam int REG_NUM    = 16;
  localparam int ADDR_W     = 5;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              core_en = 1'b0;
  logic              core_r_or_w = 1'b0;
  logic [ADDR_W-1:0] core_addr = '0;
  logic [WIDTH-1:0]  core_wdata = '0;
  logic              core_stall;
  logic              rf_en;
  logic              rf_r_or_w;
  logic [ADDR_W-1:0] rf_addr;
  logic [WIDTH-1:0]  rf_wdata;
  logic [WIDTH-1:0]  rf_rdata;

  rf_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) host_bus ();

  rf_arbiter #(
    .WIDTH(WIDTH), .REG_NUM(REG_NUM), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .core_en(core_en), .core_r_or_w(core_r_or_w), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_stall(core_stall),
    .host(host_bus),
    .rf_en(rf_en), .rf_r_or_w(rf_r_or_w), .rf_addr(rf_addr),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );

  always #5 clk = ~clk;

  // Register-file model: one-cycle read latency, address 5 preloaded with 0x1234.
  logic [WIDTH-1:0] mem [0:31];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= (i == 5) ? 16'h1234 : 16'h0000;
      rf_rdata <= '0;
    end else if (rf_en) begin
      if (rf_r_or_w) rf_rdata <= mem[rf_addr];
      else mem[rf_addr] <= rf_wdata;
    end
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] rdata;
    logic             err;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every host_ack pops one expected response.
  logic prev_ack = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (host_bus.host_ack === 1'b1) begin
      chk("ack_single_pulse", 32'(prev_ack), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got host_ack=1, expected no ack");
      end else begin
        mon_e = exp_q.pop_front();
        chk("host_rdata", 32'(host_bus.host_rdata), 32'(mon_e.rdata));
        chk("host_err", 32'(host_bus.host_err), 32'(mon_e.err));
      end
    end
    prev_ack <= host_bus.host_ack;
  end

  // Issues one host transaction at the current negedge and waits for its ack.
  task automatic host_txn(input string name, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [WIDTH-1:0] wdata, input logic [WIDTH-1:0] exp_rdata,
                          input logic exp_err, input int exp_lat, input int exp_stall,
                          input int exp_core, input logic exp_host_en, input logic hold);
    int   n = 0;
    int   stalls = 0;
    int   cores = 0;
    logic host_en_seen = 1'b0;
    logic done = 1'b0;
    exp_t e;
    host_bus.host_req   = 1'b1;
    host_bus.host_we    = we;
    host_bus.host_addr  = addr;
    host_bus.host_wdata = wdata;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    exp_q.push_back(e);
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
      if (core_stall) stalls++;
      if (core_stall && rf_en) begin
        host_en_seen = 1'b1;
        chk({name, "_rf_addr"}, 32'(rf_addr), 32'(addr));
        chk({name, "_rf_r_or_w"}, 32'(rf_r_or_w), 32'(!we));
        if (we) chk({name, "_rf_wdata"}, 32'(rf_wdata), 32'(wdata));
      end
      if (!core_stall && rf_en && core_en) begin
        cores++;
        chk({name, "_core_pass_addr"}, 32'(rf_addr), 32'(core_addr));
      end
      if (host_bus.host_ack) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no host_ack in %0d cycles, expected ack", name, n);
    end
    chk({name, "_latency"}, 32'(n), 32'(exp_lat));
    chk({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    chk({name, "_core_accesses"}, 32'(cores), 32'(exp_core));
    chk({name, "_host_rf_en"}, 32'(host_en_seen), 32'(exp_host_en));
    if (!hold) host_bus.host_req = 1'b0;
  endtask

  int late_acks;

  initial begin
    host_bus.host_req   = 1'b0;
    host_bus.host_we    = 1'b0;
    host_bus.host_addr  = '0;
    host_bus.host_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_core_stall", 32'(core_stall), 32'd0);
    chk("rst_host_ack", 32'(host_bus.host_ack), 32'd0);
    chk("rst_host_err", 32'(host_bus.host_err), 32'd0);
    chk("rst_host_rdata", 32'(host_bus.host_rdata), 32'd0);
    rst = 1'b1;

    // Core pass-through write then read.
    @(negedge clk);
    core_en = 1'b1; core_r_or_w = 1'b0; core_addr = 5'd9; core_wdata = 16'h5A5A;
    #1;
    chk("pass_rf_en", 32'(rf_en), 32'd1);
    chk("pass_rf_addr", 32'(rf_addr), 32'd9);
    chk("pass_rf_wdata", 32'(rf_wdata), 32'h5A5A);
    chk("pass_rf_r_or_w", 32'(rf_r_or_w), 32'd0);
    @(negedge clk);
    chk("core_write_mem", 32'(mem[9]), 32'h5A5A);
    core_r_or_w = 1'b1;
    @(negedge clk);
    chk("core_read_data", 32'(rf_rdata), 32'h5A5A);
    core_en = 1'b0;

    // Host write, then read back; then preloaded read.
    @(negedge clk);
    host_txn("wr3", 1'b1, 5'd3, 16'hBEEF, 16'h0000, 1'b0, 2, 2, 0, 1'b1, 1'b0);
    @(negedge clk);
    host_txn("rd3", 1'b0, 5'd3, 16'h0000, 16'hBEEF, 1'b0, 3, 3, 0, 1'b1, 1'b0);
    @(negedge clk);
    host_txn("rd5", 1'b0, 5'd5, 16'h0000, 16'h1234, 1'b0, 3, 3, 0, 1'b1, 1'b0);

    // Starvation: core keeps reading address 2.
    @(negedge clk);
    core_en = 1'b1; core_r_or_w = 1'b1; core_addr = 5'd2;
    host_txn("starve", 1'b0, 5'd5, 16'h0000, 16'h1234, 1'b0, 7, 3, 4, 1'b1, 1'b0);
    core_en = 1'b0;

    // Out-of-range addresses never reach the register file.
    @(negedge clk);
    host_txn("wr17", 1'b1, 5'd17, 16'hBEEF, 16'h0000, 1'b1, 2, 2, 0, 1'b0, 1'b0);
    chk("wr17_mem_untouched", 32'(mem[17]), 32'd0);
    @(negedge clk);
    host_txn("rd20", 1'b0, 5'd20, 16'h0000, 16'h0000, 1'b1, 2, 2, 0, 1'b0, 1'b0);

    // Reset while in HOST_RD drops the transaction.
    @(negedge clk);
    host_bus.host_req = 1'b1; host_bus.host_we = 1'b0; host_bus.host_addr = 5'd5;
    repeat (2) @(negedge clk);
    chk("host_rd_stall", 32'(core_stall), 32'd1);
    rst = 1'b0;
    host_bus.host_req = 1'b0;
    @(negedge clk);
    chk("rst_rd_core_stall", 32'(core_stall), 32'd0);
    chk("rst_rd_host_ack", 32'(host_bus.host_ack), 32'd0);
    chk("rst_rd_host_rdata", 32'(host_bus.host_rdata), 32'd0);
    rst = 1'b1;
    late_acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (host_bus.host_ack) late_acks++;
    end
    chk("rst_rd_no_ack", 32'(late_acks), 32'd0);

    // Partial starvation count must be cleared by reset.
    core_en = 1'b1; core_r_or_w = 1'b1; core_addr = 5'd2;
    host_bus.host_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("contend_no_stall", 32'(core_stall), 32'd0);
    rst = 1'b0;
    host_bus.host_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    host_txn("starve_after_rst", 1'b0, 5'd5, 16'h0000, 16'h1234, 1'b0, 7, 3, 4, 1'b1, 1'b0);
    core_en = 1'b0;

    // Back-to-back: request held across ACK.
    @(negedge clk);
    host_txn("b2b_1", 1'b1, 5'd4, 16'hA5A5, 16'h0000, 1'b0, 2, 2, 0, 1'b1, 1'b1);
    host_txn("b2b_2", 1'b0, 5'd4, 16'h0000, 16'hA5A5, 1'b0, 4, 3, 0, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
